// File: rtl/uart_rx_pkg.sv
// Shared types and default sizing for the UART receive controller.
package uart_rx_pkg;

  localparam int unsigned CLKS_PER_BIT_DFLT = 10;
  localparam int unsigned DATA_BITS_DFLT    = 8;
  localparam int unsigned TIMER_BITS        = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } rx_state_e;

endpackage

// File: rtl/flex_counter.sv
// Parameterised up-counter with clear, enable and rollover flag.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_count;

  // Clear together with enable restarts at 1, so that cycle already counts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= count_enable ? ONE : '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) r_count <= ONE;
      else                         r_count <= r_count + ONE;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronised line, mid-bit sampling, single-entry output
// buffer with overrun and framing status.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int unsigned DATA_BITS    = DATA_BITS_DFLT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  localparam int unsigned BC_BITS = $clog2(DATA_BITS + 1);
  localparam logic [TIMER_BITS-1:0] HALF_BIT = TIMER_BITS'(CLKS_PER_BIT / 2);
  localparam logic [TIMER_BITS-1:0] FULL_BIT = TIMER_BITS'(CLKS_PER_BIT);
  localparam logic [BC_BITS-1:0]    LAST_BIT = BC_BITS'(DATA_BITS - 1);
  localparam logic [BC_BITS-1:0]    ALL_BITS = BC_BITS'(DATA_BITS);

  rx_state_e r_state, w_state_n;

  logic r_sync1, r_sync2, r_sync_prev;
  logic [DATA_BITS-1:0] r_shift, r_rx_data;
  logic r_data_ready, r_overrun, r_framing;

  logic w_start_edge, w_tmr_active, w_tmr_clear, w_tmr_en, w_tmr_flag, w_strobe;
  logic [TIMER_BITS-1:0] w_tmr_roll, w_tmr_count;
  logic w_bit_clear, w_bit_en, w_bit_flag;
  logic [BC_BITS-1:0] w_bit_count;
  logic w_shift_en, w_load, w_frame_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= serial_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_start_edge = (r_state == IDLE) && !r_sync2 && r_sync_prev;
  assign w_tmr_active = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_tmr_clear  = (r_state == IDLE);
  assign w_tmr_en     = w_tmr_active || w_start_edge;
  assign w_tmr_roll   = (r_state == START) ? HALF_BIT : FULL_BIT;
  // A parked timer (count 0) never reports a strobe.
  assign w_strobe     = w_tmr_flag && w_tmr_active && (w_tmr_count != '0);
  assign w_bit_clear  = (r_state == IDLE);
  assign w_bit_en     = w_shift_en;

  flex_counter #(.NUM_CNT_BITS(TIMER_BITS)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_tmr_clear),
    .count_enable (w_tmr_en),
    .rollover_val (w_tmr_roll),
    .count_out    (w_tmr_count),
    .rollover_flag(w_tmr_flag)
  );

  flex_counter #(.NUM_CNT_BITS(BC_BITS)) u_bit_count (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_bit_clear),
    .count_enable (w_bit_en),
    .rollover_val (ALL_BITS),
    .count_out    (w_bit_count),
    .rollover_flag(w_bit_flag)
  );

  always_comb begin
    w_state_n   = r_state;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      IDLE:  if (w_start_edge) w_state_n = START;
      START: if (w_strobe) w_state_n = r_sync2 ? IDLE : DATA;
      DATA: begin
        if (w_strobe) begin
          w_shift_en = 1'b1;
          if (w_bit_count == LAST_BIT) w_state_n = STOP;
        end
      end
      STOP: begin
        if (w_strobe && w_bit_flag) begin
          if (r_sync2) begin
            w_state_n = LOAD;
          end else begin
            w_frame_err = 1'b1;
            w_state_n   = IDLE;
          end
        end
      end
      LOAD: begin
        w_load    = 1'b1;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)          r_shift <= '0;
    else if (w_shift_en) r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      r_rx_data <= '0;
    else if (w_load) r_rx_data <= r_shift;
  end

  // A read landing on the LOAD cycle consumes the old byte, so no overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_load) begin
      r_data_ready <= 1'b1;
      r_overrun    <= r_data_ready && !data_read;
    end else if (data_read) begin
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            r_framing <= 1'b0;
    else if (w_frame_err)  r_framing <= 1'b1;
    else if (w_start_edge) r_framing <= 1'b0;
  end

  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign overrun_error = r_overrun;
  assign framing_error = r_framing;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: every expected output change is queued
// ahead of the stimulus and checked by a monitor on the falling clock edge.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 10;
  localparam int unsigned DB  = 8;

  typedef struct {
    string      name;
    logic [10:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial_in = 1'b1;
  logic data_read = 1'b0;
  logic [DB-1:0] rx_data;
  logic data_ready, overrun_error, framing_error;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        exp_q[$];
  logic [10:0] prev;
  logic        mon_en = 1'b0;
  logic [10:0] w_cur;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error)
  );

  assign w_cur = {rx_data, data_ready, overrun_error, framing_error};

  function automatic logic [10:0] tup(input logic [7:0] d, input logic dr,
                                      input logic ov, input logic fe);
    return {d, dr, ov, fe};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rx=%h dr=%b ov=%b fe=%b, want rx=%h dr=%b ov=%b fe=%b",
               name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input string name, input logic [10:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && (w_cur !== prev)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_change: got rx=%h dr=%b ov=%b fe=%b, want no change from rx=%h dr=%b ov=%b fe=%b",
                 w_cur[10:3], w_cur[2], w_cur[1], w_cur[0], prev[10:3], prev[2], prev[1], prev[0]);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, w_cur, e.val);
      end
      prev = w_cur;
    end
  end

  // Called on a falling edge; holds one bit for CPB cycles, optionally
  // pulsing data_read so that it is sampled on the edge that ends LOAD.
  task automatic drive_bit(input logic b, input logic rd_in_load);
    for (int i = 0; i < int'(CPB); i++) begin
      serial_in = b;
      data_read = rd_in_load && (i == int'(CPB) - 2);
      @(negedge clk);
    end
    data_read = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_in_load);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < int'(DB); i++) drive_bit(d[i], 1'b0);
    drive_bit(stop, rd_in_load);
    serial_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;
    repeat (3) @(negedge clk);
    check("reset_state", w_cur, tup(8'h00, 1'b0, 1'b0, 1'b0));
    prev   = w_cur;
    n_rst  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    push("a5_load", tup(8'hA5, 1'b1, 1'b0, 1'b0));
    send_frame(8'hA5, 1'b1, 1'b0);
    push("a5_read", tup(8'hA5, 1'b0, 1'b0, 1'b0));
    read_pulse();

    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("false_start_hold", w_cur, tup(8'hA5, 1'b0, 1'b0, 1'b0));

    push("framing_set", tup(8'hA5, 1'b0, 1'b0, 1'b1));
    send_frame(8'h3C, 1'b0, 1'b0);

    push("framing_clear", tup(8'hA5, 1'b0, 1'b0, 1'b0));
    push("x11_load", tup(8'h11, 1'b1, 1'b0, 1'b0));
    send_frame(8'h11, 1'b1, 1'b0);
    push("x22_overrun", tup(8'h22, 1'b1, 1'b1, 1'b0));
    send_frame(8'h22, 1'b1, 1'b0);
    push("overrun_read", tup(8'h22, 1'b0, 1'b0, 1'b0));
    read_pulse();

    partial = 8'h77;
    push("midframe_reset", tup(8'h00, 1'b0, 1'b0, 1'b0));
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], 1'b0);
    serial_in = partial[4];
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1 check("reset_async", w_cur, tup(8'h00, 1'b0, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    n_rst     = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    push("x5a_load", tup(8'h5A, 1'b1, 1'b0, 1'b0));
    send_frame(8'h5A, 1'b1, 1'b0);
    push("read_in_load", tup(8'hC3, 1'b1, 1'b0, 1'b0));
    send_frame(8'hC3, 1'b1, 1'b1);
    push("final_read", tup(8'hC3, 1'b0, 1'b0, 1'b0));
    read_pulse();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expectations, want 0 (next: %s)",
               exp_q.size(), exp_q[0].name);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
